// File: rtl/io_led_pkg.sv
// Shared register map and CTRL bit positions for the io_led_pwm LED block.
package io_led_pkg;

    // Word offsets from BASE_ADR
    localparam logic [13:0] OFS_LED_VAL  = 14'd0;
    localparam logic [13:0] OFS_CTRL     = 14'd1;
    localparam logic [13:0] OFS_PRESC    = 14'd2;
    localparam logic [13:0] OFS_BLINK_HP = 14'd3;
    localparam logic [13:0] OFS_DUTY0    = 14'd4;

    // CTRL register bits
    localparam int unsigned CTRL_PWM_ON   = 0;
    localparam int unsigned CTRL_BLINK_ON = 1;

endpackage

// File: rtl/led_pwm_ch.sv
// One LED channel: DUTY register, period-aligned duty shadow, PWM compare
// and registered output.
module led_pwm_ch #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                duty_we,
    input  logic [PWM_BITS-1:0] wdata,
    input  logic                load_sh,
    input  logic                pwm_on,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                led_en,
    output logic [PWM_BITS-1:0] duty,
    output logic                led
);

    logic [PWM_BITS-1:0] duty_sh;
    logic                on;

    // Software-visible DUTY register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          duty <= '0;
        else if (duty_we) duty <= wdata;
    end

    // Shadow only follows DUTY at period boundaries so a period never mixes two duties
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          duty_sh <= '0;
        else if (load_sh) duty_sh <= duty;
    end

    // All-ones duty means fully on, so it cannot rely on the strict compare
    always_comb begin
        on = led_en;
        if (pwm_on) on = led_en & ((duty_sh == '1) | (pwm_cnt < duty_sh));
    end

    // Registered LED drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) led <= 1'b0;
        else     led <= on;
    end

endmodule

// File: rtl/io_led_pwm.sv
// Multi-channel LED block on the DMA IO bus: register decode, read chain mux,
// prescaler, PWM counter and optional blink.
// Blink logic is present only when IO_LED_PWM_BLINK_EN is defined; otherwise
// CTRL bit1 and BLINK_HP read as zero and ignore writes.
module io_led_pwm
    import io_led_pkg::*;
#(
    parameter int unsigned NCH      = 3,
    parameter int unsigned PWM_BITS = 8,
    parameter logic [13:0] BASE_ADR = 14'h3F80
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dma_io_we,
    input  logic [15:2]         dma_io_wadr,
    input  logic [15:0]         dma_io_wdata,
    input  logic [15:2]         dma_io_radr,
    input  logic [15:0]         dma_io_rdata_in,
    output logic [15:0]         dma_io_rdata,
    output logic [NCH-1:0]      led_out
);

    localparam logic [13:0] NREG = OFS_DUTY0 + 14'(NCH);

    logic [13:0]         wofs, rofs;
    logic                wr, rhit;
    logic                wr_led, wr_ctrl, wr_presc;
    logic [NCH-1:0]      led_val;
    logic                pwm_on;
    logic [15:0]         presc, psc_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick, period_end, pwm_start, load_sh;
    logic                blink_gate;
    logic [15:0]         ctrl_rd, bhp_rd;
    logic [PWM_BITS-1:0] duty [NCH];

    assign wofs     = dma_io_wadr - BASE_ADR;
    assign rofs     = dma_io_radr - BASE_ADR;
    assign wr       = dma_io_we && (dma_io_wadr >= BASE_ADR) && (wofs < NREG);
    assign rhit     = (dma_io_radr >= BASE_ADR) && (rofs < NREG);
    assign wr_led   = wr && (wofs == OFS_LED_VAL);
    assign wr_ctrl  = wr && (wofs == OFS_CTRL);
    assign wr_presc = wr && (wofs == OFS_PRESC);

    assign pwm_start  = wr_ctrl & dma_io_wdata[CTRL_PWM_ON] & ~pwm_on;
    assign tick       = (psc_cnt == presc);
    assign period_end = tick & (pwm_cnt == '1);
    assign load_sh    = period_end | ~pwm_on;

    // LED_VAL, CTRL.PWM_ON and PRESC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_val <= '0;
            pwm_on  <= 1'b0;
            presc   <= '0;
        end else begin
            if (wr_led)   led_val <= dma_io_wdata[NCH-1:0];
            if (wr_ctrl)  pwm_on  <= dma_io_wdata[CTRL_PWM_ON];
            if (wr_presc) presc   <= dma_io_wdata;
        end
    end

    // Prescaler: register writes restart the count ahead of the tick wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        psc_cnt <= '0;
        else if (wr_presc || pwm_start) psc_cnt <= '0;
        else if (tick)                  psc_cnt <= '0;
        else                            psc_cnt <= psc_cnt + 16'd1;
    end

    // PWM counter; enabling PWM starts a fresh period
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            pwm_cnt <= '0;
        else if (pwm_start) pwm_cnt <= '0;
        else if (tick)      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

`ifdef IO_LED_PWM_BLINK_EN
    logic        blink_on, phase, blk_ev, blink_start, wr_bhp;
    logic [15:0] blink_hp, blk_cnt;

    assign wr_bhp      = wr && (wofs == OFS_BLINK_HP);
    assign blink_start = wr_ctrl & dma_io_wdata[CTRL_BLINK_ON] & ~blink_on;
    assign blk_ev      = pwm_on ? period_end : tick;

    // CTRL.BLINK_ON and BLINK_HP registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_on <= 1'b0;
            blink_hp <= '0;
        end else begin
            if (wr_ctrl) blink_on <= dma_io_wdata[CTRL_BLINK_ON];
            if (wr_bhp)  blink_hp <= dma_io_wdata;
        end
    end

    // Half-period counter; enabling blink starts in the lit phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt <= '0;
            phase   <= 1'b0;
        end else if (blink_start) begin
            blk_cnt <= '0;
            phase   <= 1'b1;
        end else if (wr_bhp) begin
            blk_cnt <= '0;
        end else if (blk_ev) begin
            if (blk_cnt == blink_hp) begin
                blk_cnt <= '0;
                phase   <= ~phase;
            end else begin
                blk_cnt <= blk_cnt + 16'd1;
            end
        end
    end

    assign blink_gate = ~blink_on | phase;
    assign ctrl_rd    = {14'd0, blink_on, pwm_on};
    assign bhp_rd     = blink_hp;
`else
    assign blink_gate = 1'b1;
    assign ctrl_rd    = {15'd0, pwm_on};
    assign bhp_rd     = '0;
`endif

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        led_pwm_ch #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .duty_we (wr && (wofs == OFS_DUTY0 + 14'(n))),
            .wdata   (dma_io_wdata[PWM_BITS-1:0]),
            .load_sh (load_sh),
            .pwm_on  (pwm_on),
            .pwm_cnt (pwm_cnt),
            .led_en  (led_val[n] & blink_gate),
            .duty    (duty[n]),
            .led     (led_out[n])
        );
    end

    // Read chain: own registers on hit, upstream data otherwise
    always_comb begin
        dma_io_rdata = dma_io_rdata_in;
        if (rhit) begin
            dma_io_rdata = '0;
            case (rofs)
                OFS_LED_VAL:  dma_io_rdata[NCH-1:0] = led_val;
                OFS_CTRL:     dma_io_rdata = ctrl_rd;
                OFS_PRESC:    dma_io_rdata = presc;
                OFS_BLINK_HP: dma_io_rdata = bhp_rd;
                default: begin
                    for (int unsigned i = 0; i < NCH; i++) begin
                        if (rofs == OFS_DUTY0 + 14'(i)) dma_io_rdata[PWM_BITS-1:0] = duty[i];
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_led_pwm.sv
// Self-checking bench for io_led_pwm (default NCH=3, PWM_BITS=8).
module tb_io_led_pwm;

    localparam int unsigned NCH      = 3;
    localparam int unsigned PWM_BITS = 8;
    localparam logic [13:0] BASE     = 14'h3F80;

    logic           clk      = 1'b0;
    logic           rst      = 1'b1;
    logic           we       = 1'b0;
    logic [13:0]    wadr     = '0;
    logic [13:0]    radr     = '0;
    logic [15:0]    wdata    = '0;
    logic [15:0]    rdata_in = 16'hBEEF;
    logic [15:0]    rdata;
    logic [NCH-1:0] led_out;

    io_led_pwm #(.NCH(NCH), .PWM_BITS(PWM_BITS), .BASE_ADR(BASE)) dut (
        .clk             (clk),
        .rst             (rst),
        .dma_io_we       (we),
        .dma_io_wadr     (wadr),
        .dma_io_wdata    (wdata),
        .dma_io_radr     (radr),
        .dma_io_rdata_in (rdata_in),
        .dma_io_rdata    (rdata),
        .led_out         (led_out)
    );

    always #5 clk = ~clk;

    // running count of clocks with led_out[0] high
    int hi_cnt = 0;
    always @(posedge clk) hi_cnt <= hi_cnt + int'(led_out[0]);

    typedef struct { string name; logic [15:0] exp; } exp_t;
    typedef struct { string name; int ofs; logic [15:0] wd; logic [15:0] rd; } vec_t;

    exp_t sb[$];
    vec_t vt[9];
    int   total = 0;
    int   bad   = 0;

    task automatic push_exp(input string name, input logic [15:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [15:0] act);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty actual=%h", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s actual=%h expected=%h", e.name, act, e.exp);
            end
        end
    endtask

    // Called in the low clock phase; the write lands on the next rising edge
    task automatic wr(input int ofs, input logic [15:0] d);
        we    = 1'b1;
        wadr  = BASE + 14'(ofs);
        wdata = d;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic rd_chk(input string name, input int ofs, input logic [15:0] exp);
        radr = BASE + 14'(ofs);
        push_exp(name, exp);
        #1;
        pop_cmp(rdata);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic led_chk(input string name, input logic [NCH-1:0] exp);
        push_exp(name, 16'(exp));
        pop_cmp(16'(led_out));
    endtask

    task automatic count_chk(input string name, input int n, input int exp);
        int h0;
        h0 = hi_cnt;
        push_exp(name, 16'(exp));
        wait_n(n);
        pop_cmp(16'(hi_cnt - h0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;

        vt[0] = '{"rb_led_val",  0, 16'hFFFF, 16'h0007};
`ifdef IO_LED_PWM_BLINK_EN
        vt[1] = '{"rb_ctrl",     1, 16'hFFFF, 16'h0003};
        vt[3] = '{"rb_blink_hp", 3, 16'h1234, 16'h1234};
`else
        vt[1] = '{"rb_ctrl",     1, 16'hFFFF, 16'h0001};
        vt[3] = '{"rb_blink_hp", 3, 16'h1234, 16'h0000};
`endif
        vt[2] = '{"rb_presc",    2, 16'hABCD, 16'hABCD};
        vt[4] = '{"rb_duty0",    4, 16'h01FF, 16'h00FF};
        vt[5] = '{"rb_duty1",    5, 16'h0042, 16'h0042};
        vt[6] = '{"rb_duty2",    6, 16'hA5C3, 16'h00C3};
        vt[7] = '{"rb_miss_hi",  7, 16'h1111, 16'hBEEF};
        vt[8] = '{"rb_miss_lo", -1, 16'h2222, 16'hBEEF};

        // reset state
        @(negedge clk);
        wait_n(2);
        led_chk("rst_led", '0);
        for (int i = 0; i < 7; i++) rd_chk("rst_reg", i, 16'h0000);
        rd_chk("rst_miss", 7, 16'hBEEF);
        wait_n(1);
        rst = 1'b0;
        wait_n(1);

        // register write / readback table
        for (int i = 0; i < 9; i++) begin
            wr(vt[i].ofs, vt[i].wd);
            rd_chk(vt[i].name, vt[i].ofs, vt[i].rd);
        end

        // asynchronous reset in the middle of operation
        wait_n(20);
        rst = 1'b1;
        #1;
        led_chk("midrst_led", '0);
        for (int i = 0; i < 7; i++) rd_chk("midrst_reg", i, 16'h0000);
        rdata_in = 16'h1234;
        rd_chk("midrst_miss", 7, 16'h1234);
        wait_n(1);
        rst = 1'b0;
        wait_n(1);

        // compatible on/off port: two clocks from strobe to pin
        wr(0, 16'h0005);
        led_chk("compat_lat1", 3'b000);
        wait_n(1);
        led_chk("compat_lat2", 3'b101);
        rd_chk("compat_rd", 0, 16'h0005);

        // PWM, PRESC=0, DUTY0=64
        wr(4, 16'd64);
        wr(0, 16'h0001);
        wr(1, 16'h0001);
        wait_n(1);
        count_chk("pwm64_a", 256, 64);
        count_chk("pwm64_b", 256, 64);

        // duty change at pwm_cnt=10: current period keeps 64
        h0 = hi_cnt;
        push_exp("duty_keep", 16'd64);
        wait_n(9);
        wr(4, 16'd128);
        wait_n(246);
        pop_cmp(16'(hi_cnt - h0));
        count_chk("duty_next", 256, 128);

        // duty boundaries
        wr(4, 16'd255);
        wait_n(300);
        count_chk("duty_full", 256, 256);
        wr(4, 16'd0);
        wait_n(300);
        count_chk("duty_zero", 256, 0);

        // prescaler PRESC=3, DUTY0=2
        wr(1, 16'h0000);
        wr(4, 16'd2);
        wr(2, 16'd3);
        wr(1, 16'h0001);
        wait_n(1);
        count_chk("presc3", 1024, 8);

        // PRESC rewrite two clocks into a tick interval stretches pwm_cnt=1 by 3 clocks
        h0 = hi_cnt;
        push_exp("presc_restart", 16'd11);
        wait_n(5);
        wr(2, 16'd3);
        wait_n(1018);
        pop_cmp(16'(hi_cnt - h0));

`ifdef IO_LED_PWM_BLINK_EN
        wr(1, 16'h0000);
        wr(2, 16'd0);
        wr(4, 16'd255);
        wr(3, 16'd1);
        wr(0, 16'h0001);
        wr(1, 16'h0003);
        wait_n(1);
        count_chk("blink_on",  512, 512);
        count_chk("blink_off", 512, 0);
        count_chk("blink_on2", 512, 512);
`else
        wr(1, 16'h0003);
        rd_chk("ctrl_noblink", 1, 16'h0001);
        wr(3, 16'h0007);
        rd_chk("bhp_noblink", 3, 16'h0000);
`endif

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
